instr_decode: RTL and testbench

- Decode stage directly downstream of the fetch stage.
- Accepts 32-bit RV32I instruction words plus their PC from fetch through a valid/ready handshake.
- Produces registered, fully decoded fields: register indices, sign-extended immediate, control strobes and an illegal flag for the execute stage.
- Holds a 2-entry skid buffer, so downstream backpressure never drops or duplicates an instruction.

---
 rtl/instr_decode.sv | 256 +++++++++++++++++++++++++
 tb/tb_instr_decode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// RV32I decode stage sitting directly behind fetch.
// Decodes in_instr combinationally and registers the result into a
// two-entry buffer: an output register plus a skid entry. Backpressure
// from execute therefore never drops or duplicates an instruction.
//
// Handshake: a beat moves on any interface when valid && ready are both
// high at the rising clk edge. A producer holds its data stable while
// valid is high and ready is low. The bundle on out_* is always
// registered and holds stable while out_valid && !out_ready.
//
// Optional feature (macro DECODE_PERF_CNT_EN): adds the saturating
// counters perf_decoded and perf_illegal, counting bundles accepted by
// execute and, among those, the ones flagged illegal.
module instr_decode #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [2:0]            out_funct3,
    output logic                  out_funct7b5,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_reg_wr,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic                  out_alu_imm,
    output logic                  out_branch,
    output logic                  out_jal,
    output logic                  out_jalr,
    output logic                  out_lui,
    output logic                  out_auipc,
`ifdef DECODE_PERF_CNT_EN
    output logic [15:0]           perf_decoded,
    output logic [15:0]           perf_illegal,
`endif
    output logic                  out_illegal
);

    // One fully decoded instruction as it travels through the buffer.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic [DATA_WIDTH-1:0] imm;
        logic                  reg_wr;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  alu_imm;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic                  lui;
        logic                  auipc;
        logic                  illegal;
    } bundle_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int XW = DATA_WIDTH;

    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;
    logic    accept;
    logic    out_fire;

    logic [XW-1:0] imm_i;
    logic [XW-1:0] imm_s;
    logic [XW-1:0] imm_b;
    logic [XW-1:0] imm_u;
    logic [XW-1:0] imm_j;

    // Immediate formats, all sign-extended from instr[31] except U.
    always_comb begin
        imm_i = {{(XW-12){in_instr[31]}}, in_instr[31:20]};
        imm_s = {{(XW-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b = {{(XW-13){in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
        imm_u = {{(XW-32){in_instr[31]}}, in_instr[31:12], 12'b0};
        imm_j = {{(XW-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
    end

    // Opcode decode into a bundle; unknown opcodes only raise illegal.
    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = in_instr[14:12];
        dec.funct7b5 = in_instr[30];
        case (in_instr[6:0])
            OP_R: begin
                dec.reg_wr = 1'b1;
            end
            OP_I_ALU: begin
                dec.reg_wr  = 1'b1;
                dec.alu_imm = 1'b1;
                dec.imm     = imm_i;
            end
            OP_LOAD: begin
                dec.reg_wr  = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.alu_imm = 1'b1;
                dec.imm     = imm_i;
            end
            OP_STORE: begin
                dec.mem_wr  = 1'b1;
                dec.alu_imm = 1'b1;
                dec.imm     = imm_s;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
            end
            OP_JAL: begin
                dec.reg_wr = 1'b1;
                dec.jal    = 1'b1;
                dec.imm    = imm_j;
            end
            OP_JALR: begin
                dec.reg_wr  = 1'b1;
                dec.jalr    = 1'b1;
                dec.alu_imm = 1'b1;
                dec.imm     = imm_i;
            end
            OP_LUI: begin
                dec.reg_wr = 1'b1;
                dec.lui    = 1'b1;
                dec.imm    = imm_u;
            end
            OP_AUIPC: begin
                dec.reg_wr = 1'b1;
                dec.auipc  = 1'b1;
                dec.imm    = imm_u;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally dropped, so never request one.
        if (dec.rd == 5'd0) begin
            dec.reg_wr = 1'b0;
        end
    end

    // Ready depends only on the registered skid state (held low in reset).
    always_comb begin
        in_ready = !skid_valid_q && !rst;
        accept   = in_valid && in_ready;
        out_fire = out_valid_q && out_ready;
    end

    // Output register plus skid entry; order is output first, then skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_fire) begin
            // Output slot is free this edge: refill from skid, else input.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            // Output is stalled; accept implies the skid entry is empty.
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    always_comb begin
        out_valid    = out_valid_q;
        out_pc       = out_q.pc;
        out_rd       = out_q.rd;
        out_rs1      = out_q.rs1;
        out_rs2      = out_q.rs2;
        out_funct3   = out_q.funct3;
        out_funct7b5 = out_q.funct7b5;
        out_imm      = out_q.imm;
        out_reg_wr   = out_q.reg_wr;
        out_mem_rd   = out_q.mem_rd;
        out_mem_wr   = out_q.mem_wr;
        out_alu_imm  = out_q.alu_imm;
        out_branch   = out_q.branch;
        out_jal      = out_q.jal;
        out_jalr     = out_q.jalr;
        out_lui      = out_q.lui;
        out_auipc    = out_q.auipc;
        out_illegal  = out_q.illegal;
    end

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_decoded_q;
    logic [15:0] perf_illegal_q;

    // Saturating counts of bundles taken by execute; flush does not clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else if (out_fire) begin
            if (perf_decoded_q != 16'hFFFF) begin
                perf_decoded_q <= perf_decoded_q + 16'd1;
            end
            if (out_q.illegal && (perf_illegal_q != 16'hFFFF)) begin
                perf_illegal_q <= perf_illegal_q + 16'd1;
            end
        end
    end

    always_comb begin
        perf_decoded = perf_decoded_q;
        perf_illegal = perf_illegal_q;
    end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: reset, single decode, back-to-back
// formats, skid backpressure, illegal/x0 cases, flush and (when the
// DECODE_PERF_CNT_EN macro is defined) the performance counters.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [10:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [31:0] out_imm;
    logic        out_reg_wr, out_mem_rd, out_mem_wr, out_alu_imm, out_branch;
    logic        out_jal, out_jalr, out_lui, out_auipc, out_illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_decoded, perf_illegal;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Strobes packed as {reg_wr, mem_rd, mem_wr, alu_imm, branch, jal, jalr, lui, auipc}
    logic [8:0] strobes;
    assign strobes = {out_reg_wr, out_mem_rd, out_mem_wr, out_alu_imm, out_branch,
                      out_jal, out_jalr, out_lui, out_auipc};

    instr_decode dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_imm(out_imm),
        .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_alu_imm(out_alu_imm), .out_branch(out_branch), .out_jal(out_jal),
        .out_jalr(out_jalr), .out_lui(out_lui), .out_auipc(out_auipc),
`ifdef DECODE_PERF_CNT_EN
        .perf_decoded(perf_decoded), .perf_illegal(perf_illegal),
`endif
        .out_illegal(out_illegal)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
        check_cnt++; if ({strobes, out_illegal, out_imm, out_pc} !== '0)
            $display("FAIL reset_fields got %h/%b/%h/%h exp 0", strobes, out_illegal, out_imm, out_pc); else pass_cnt++;
        rst = 1'b0;
        step();
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_addi();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 11'd3;
        step();
        in_valid = 1'b0;
        check_cnt++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b exp 1", out_valid); else pass_cnt++;
        check_cnt++; if ({out_rd, out_rs1, out_pc} !== {5'd1, 5'd0, 11'd3})
            $display("FAIL addi_regs got rd=%0d rs1=%0d pc=%0d exp 1 0 3", out_rd, out_rs1, out_pc); else pass_cnt++;
        check_cnt++; if (out_imm !== 32'd5) $display("FAIL addi_imm got %h exp 00000005", out_imm); else pass_cnt++;
        check_cnt++; if ({strobes, out_illegal} !== {9'b100100000, 1'b0})
            $display("FAIL addi_strobes got %b/%b exp 100100000/0", strobes, out_illegal); else pass_cnt++;
        step();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_v [4];
        logic [31:0] imm_v   [4];
        logic [8:0]  str_v   [4];
        logic [4:0]  rd_v    [4];
        instr_v = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h010000EF};
        imm_v   = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000010};
        str_v   = '{9'b001100000, 9'b000010000, 9'b100000010, 9'b100001000};
        rd_v    = '{5'd8, 5'd29, 5'd5, 5'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = instr_v[i]; in_pc = 11'(10 + i);
            step();
            check_cnt++; if ({out_valid, out_pc, out_rd} !== {1'b1, 11'(10 + i), rd_v[i]})
                $display("FAIL b2b_%0d_hdr got v=%b pc=%0d rd=%0d exp 1 %0d %0d", i, out_valid, out_pc, out_rd, 10 + i, rd_v[i]); else pass_cnt++;
            check_cnt++; if (out_imm !== imm_v[i]) $display("FAIL b2b_%0d_imm got %h exp %h", i, out_imm, imm_v[i]); else pass_cnt++;
            check_cnt++; if ({strobes, out_illegal} !== {str_v[i], 1'b0})
                $display("FAIL b2b_%0d_strobes got %b/%b exp %b/0", i, strobes, out_illegal, str_v[i]); else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; in_pc = 11'd20;
        step(); // A into output register
        check_cnt++; if ({out_valid, out_imm, in_ready} !== {1'b1, 32'd1, 1'b1})
            $display("FAIL skid_a got v=%b imm=%h rdy=%b exp 1 1 1", out_valid, out_imm, in_ready); else pass_cnt++;
        in_instr = 32'h00200093; in_pc = 11'd21;
        step(); // B into skid entry
        check_cnt++; if ({in_ready, out_imm} !== {1'b0, 32'd1})
            $display("FAIL skid_b got rdy=%b imm=%h exp 0 1", in_ready, out_imm); else pass_cnt++;
        in_instr = 32'h00300093; in_pc = 11'd22;
        step(); // C refused, output holds A
        check_cnt++; if ({out_valid, out_imm, out_pc, in_ready} !== {1'b1, 32'd1, 11'd20, 1'b0})
            $display("FAIL skid_hold got v=%b imm=%h pc=%0d rdy=%b exp 1 1 20 0", out_valid, out_imm, out_pc, in_ready); else pass_cnt++;
        out_ready = 1'b1;
        step(); // A taken, B moves up
        check_cnt++; if ({out_valid, out_imm, out_pc, in_ready} !== {1'b1, 32'd2, 11'd21, 1'b1})
            $display("FAIL skid_drain_b got v=%b imm=%h pc=%0d rdy=%b exp 1 2 21 1", out_valid, out_imm, out_pc, in_ready); else pass_cnt++;
        step(); // C accepted
        in_valid = 1'b0;
        check_cnt++; if ({out_valid, out_imm, out_pc} !== {1'b1, 32'd3, 11'd22})
            $display("FAIL skid_drain_c got v=%b imm=%h pc=%0d exp 1 3 22", out_valid, out_imm, out_pc); else pass_cnt++;
        step();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL skid_empty got %b exp 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 11'd30;
        step();
        check_cnt++; if ({out_valid, out_illegal, strobes, out_imm} !== {1'b1, 1'b1, 9'b0, 32'd0})
            $display("FAIL illegal_zero got v=%b ill=%b str=%b imm=%h exp 1 1 0 0", out_valid, out_illegal, strobes, out_imm); else pass_cnt++;
        in_instr = 32'h00000013;
        step();
        in_valid = 1'b0;
        check_cnt++; if ({out_valid, out_illegal, strobes} !== {1'b1, 1'b0, 9'b000100000})
            $display("FAIL nop_x0 got v=%b ill=%b str=%b exp 1 0 000100000", out_valid, out_illegal, strobes); else pass_cnt++;
        step();
    endtask

    task automatic test_flush();
        // Flush with both entries full and a new instruction offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00400093; step();
        in_instr = 32'h00500093; step();
        in_instr = 32'h00600093; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_cnt++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_full got v=%b rdy=%b exp 0 1", out_valid, in_ready); else pass_cnt++;
        out_ready = 1'b1;
        step();
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got %b exp 0", out_valid); else pass_cnt++;
        // Flush with empty buffer discards the same-cycle handshake.
        in_valid = 1'b1; in_instr = 32'h00800093; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_incoming got %b exp 0", out_valid); else pass_cnt++;
        in_valid = 1'b1; in_instr = 32'h00700093;
        step();
        in_valid = 1'b0;
        check_cnt++; if ({out_valid, out_imm} !== {1'b1, 32'd7})
            $display("FAIL flush_resume got v=%b imm=%h exp 1 7", out_valid, out_imm); else pass_cnt++;
        step();
    endtask

`ifdef DECODE_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] seq [7];
        seq = '{32'h00100093, 32'h00000000, 32'h00200093, 32'h00300093,
                32'h00000000, 32'h00400093, 32'h00500093};
        rst = 1'b1; step(); rst = 1'b0; step();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_instr = seq[i];
            step();
        end
        in_valid = 1'b0;
        step();
        check_cnt++; if ({perf_decoded, perf_illegal} !== {16'd7, 16'd2})
            $display("FAIL perf_count got %0d/%0d exp 7/2", perf_decoded, perf_illegal); else pass_cnt++;
        in_valid = 1'b1; in_instr = 32'h00000000;
        repeat (65535) @(posedge clk);
        #1 in_valid = 1'b0;
        step(); step();
        check_cnt++; if ({perf_decoded, perf_illegal} !== {16'hFFFF, 16'hFFFF})
            $display("FAIL perf_sat got %h/%h exp ffff/ffff", perf_decoded, perf_illegal); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_skid();
        test_illegal();
        test_flush();
`ifdef DECODE_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
